flag_stim_sequencer: RTL and testbench
======================================

Name: flag_stim_sequencer

Overview:
Transmit-side counterpart of the three-flag evaluator. It accepts 3-bit flag patterns over a valid/ready handshake and drives them onto the x/y/z flag lines for a programmable hold time. It samples the evaluator's returned flag at the end of each hold window and compares it against the expected value (x&y)|(y&z). Mismatches are counted and pulsed. It sits between a test/config master and the flag evaluator.

Parameters:
HOLD_CYCLES, 2, cycles each pattern is driven on x/y/z; legal range is 1 or more.
GAP_CYCLES, 0, cycles of 000 driven after each hold window; 0 means no gap state.
CNT_W, 8, width of the saturating mismatch counter.

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pat_valid  input  1  pattern offered
pat_data  input  3  pattern bits {x,y,z}, MSB is x
pat_ready  output  1  sequencer can accept a pattern
x  output  1  flag x to evaluator
y  output  1  flag y to evaluator
z  output  1  flag z to evaluator
flag_in  input  1  evaluator result (combinational from x/y/z)
clr_err  input  1  synchronous clear of err_cnt
busy  output  1  high in DRIVE or GAP
done  output  1  one-cycle pulse when a pattern's check completes
exp_out  output  1  expected flag for the current/last pattern
mismatch  output  1  one-cycle pulse, coincident with done, when flag_in differs from exp_out
err_cnt  output  CNT_W  saturating count of mismatches

Behaviour:
- Reset (async, rst_n=0):
  - state is IDLE.
  - x, y, z, exp_out, done, mismatch, busy are 0.
  - err_cnt is 0.
  - pat_ready is 1 once out of reset.
- All outputs are registered except pat_ready and busy, which decode directly from state.
- States are IDLE, DRIVE, GAP.
- IDLE:
  - pat_ready=1 and x/y/z=000.
  - Accept when pat_valid&&pat_ready. The pattern is registered and appears on x/y/z the next cycle.
  - On accept: exp_out <= (p[2]&p[1])|(p[1]&p[0]); hold counter loads HOLD_CYCLES-1; go to DRIVE.
- DRIVE:
  - pat_ready=0; x/y/z are held stable.
  - The counter decrements each cycle.
  - On the cycle the counter equals 0, flag_in is sampled.
  - Next cycle: done=1, and mismatch=(flag_in_sampled != exp_out).
  - Then go to GAP if GAP_CYCLES>0, else to IDLE.
  - x/y/z go to 000 in the same cycle done asserts.
- GAP:
  - x/y/z=000 for exactly GAP_CYCLES cycles, then IDLE.
- Throughput: each pattern occupies HOLD_CYCLES+GAP_CYCLES+1 cycles from accept to the next possible accept. One IDLE cycle always separates patterns.
- pat_valid while pat_ready=0 is ignored. The master must hold pat_data stable until accepted.
- err_cnt:
  - Increments by 1 on mismatch and saturates at all-ones.
  - clr_err has priority: if clr_err and mismatch occur in the same cycle, err_cnt becomes 0.
- exp_out holds its last value until the next accept.
- Reset mid-DRIVE or mid-GAP: immediately return to IDLE. x/y/z drop to 000 asynchronously. No done or mismatch is produced for the aborted pattern.
- HOLD_CYCLES=1: flag_in is sampled on the first drive cycle.

Decomposition:
- Package flag_pkg holds:
  - the state enum (IDLE, DRIVE, GAP);
  - function flag_expected(x,y,z) returning (x&y)|(y&z);
  - localparam PAT_W=3.
- One sub-module, flag_sat_counter: CNT_W-wide saturating counter with inc and clr inputs, clr priority.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Required: xyz=000, pat_ready=1, err_cnt=0, done=0.
- Pattern 111 with a correct evaluator attached. Required: xyz=111 for 2 cycles starting one cycle after accept; exp_out=1; done pulses at accept+3; mismatch=0; err_cnt=0.
- Pattern 101 with flag_in forced to 1. Required: exp_out=0; mismatch pulses with done; err_cnt=1. Then pattern 011 with a correct flag. Required: err_cnt stays 1.
- Back-to-back patterns 001, 110, 011 with pat_valid held high and GAP_CYCLES=0. Required: each accepted exactly one IDLE cycle apart; exp_out sequence is 0, 1, 1.
- With CNT_W=2, apply 5 consecutive forced mismatches. Required: err_cnt saturates at 3. Then clr_err coincident with a mismatch. Required: err_cnt=0.
- Assert rst_n low during the first DRIVE cycle of pattern 111. Required: xyz=000 immediately; no done pulse; after release pat_ready=1 and err_cnt=0.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared types and helpers for the three-flag stimulus sequencer.
package flag_pkg;

  localparam int PAT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Reference evaluator function: (x&y)|(y&z).
  function automatic logic flag_expected(input logic fx, input logic fy, input logic fz);
    return (fx & fy) | (fy & fz);
  endfunction

endpackage

// File: rtl/flag_sat_counter.sv
// Saturating up-counter; a clear wins over a simultaneous increment.
module flag_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flag_stim_sequencer.sv
// Drives accepted 3-bit patterns onto x/y/z for a hold window, then checks
// the evaluator's answer against (x&y)|(y&z) and counts mismatches.
module flag_stim_sequencer
  import flag_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pat_valid,
  input  logic [PAT_W-1:0] pat_data,
  output logic             pat_ready,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             flag_in,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic             exp_out,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  // One down-counter serves both the hold and the gap window.
  localparam int MAX_WIN = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic [TW-1:0]    tmr, tmr_nxt;
  logic [PAT_W-1:0] pat, pat_nxt;
  logic             exp_nxt, done_nxt, mism_nxt;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    pat_nxt   = pat;
    exp_nxt   = exp_out;
    done_nxt  = 1'b0;
    mism_nxt  = 1'b0;
    case (state)
      IDLE: begin
        pat_nxt = '0;
        if (pat_valid) begin
          pat_nxt   = pat_data;
          exp_nxt   = flag_expected(pat_data[2], pat_data[1], pat_data[0]);
          tmr_nxt   = HOLD_LOAD;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (tmr == '0) begin
          // Last hold cycle: the evaluator output is settled, judge it now.
          done_nxt = 1'b1;
          mism_nxt = (flag_in != exp_out);
          pat_nxt  = '0;
          if (GAP_CYCLES > 0) begin
            tmr_nxt   = GAP_LOAD;
            state_nxt = GAP;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      GAP: begin
        if (tmr == '0) begin
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        pat_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tmr      <= '0;
      pat      <= '0;
      exp_out  <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      pat      <= pat_nxt;
      exp_out  <= exp_nxt;
      done     <= done_nxt;
      mismatch <= mism_nxt;
    end
  end

  // Counter sees the same pulse that is registered into mismatch, so both move together.
  flag_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mism_nxt),
    .clr   (clr_err),
    .cnt   (err_cnt)
  );

  assign pat_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign x         = pat[2];
  assign y         = pat[1];
  assign z         = pat[0];

endmodule

// File: tb/tb_flag_stim_sequencer.sv
// Directed bench: two sequencer instances (hold 2/no gap/8-bit count and
// hold 1/gap 2/2-bit count), each fed by a model evaluator with a force option.
module tb_flag_stim_sequencer;
  import flag_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 1: HOLD=2, GAP=0, CNT_W=8
  logic       valid1 = 1'b0, clr1 = 1'b0, force1 = 1'b0, fval1 = 1'b0;
  logic [2:0] data1 = '0;
  logic       ready1, x1, y1, z1, flag1, busy1, done1, exp1, mis1;
  logic [7:0] err1;
  assign flag1 = force1 ? fval1 : flag_expected(x1, y1, z1);

  flag_stim_sequencer #(.HOLD_CYCLES(2), .GAP_CYCLES(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .pat_valid(valid1), .pat_data(data1), .pat_ready(ready1),
    .x(x1), .y(y1), .z(z1), .flag_in(flag1), .clr_err(clr1), .busy(busy1),
    .done(done1), .exp_out(exp1), .mismatch(mis1), .err_cnt(err1)
  );

  // Instance 2: HOLD=1, GAP=2, CNT_W=2
  logic       valid2 = 1'b0, clr2 = 1'b0, force2 = 1'b0, fval2 = 1'b0;
  logic [2:0] data2 = '0;
  logic       ready2, x2, y2, z2, flag2, busy2, done2, exp2, mis2;
  logic [1:0] err2;
  assign flag2 = force2 ? fval2 : flag_expected(x2, y2, z2);

  flag_stim_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pat_valid(valid2), .pat_data(data2), .pat_ready(ready2),
    .x(x2), .y(y2), .z(z2), .flag_in(flag2), .clr_err(clr2), .busy(busy2),
    .done(done2), .exp_out(exp2), .mismatch(mis2), .err_cnt(err2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pattern through instance 1; accept cycle is the current cycle.
  task automatic run1(input logic [2:0] p, input logic fen, input logic fv,
                      input logic e_exp, input logic e_mis, input int e_err);
    force1 = fen; fval1 = fv;
    valid1 = 1'b1; data1 = p;
    chk("r1_ready_pre", ready1, 1);
    tick();
    valid1 = 1'b0;
    chk("r1_xyz_d1", {x1, y1, z1}, p);
    chk("r1_exp", exp1, e_exp);
    chk("r1_busy", busy1, 1);
    chk("r1_ready_drive", ready1, 0);
    chk("r1_done_d1", done1, 0);
    tick();
    chk("r1_xyz_d2", {x1, y1, z1}, p);
    chk("r1_done_d2", done1, 0);
    tick();
    chk("r1_done", done1, 1);
    chk("r1_mismatch", mis1, e_mis);
    chk("r1_xyz_off", {x1, y1, z1}, 0);
    chk("r1_err", err1, e_err);
    chk("r1_ready_post", ready1, 1);
    tick();
    chk("r1_done_low", done1, 0);
    chk("r1_mis_low", mis1, 0);
    chk("r1_err_hold", err1, e_err);
    force1 = 1'b0;
  endtask

  // One pattern through instance 2 (done at accept+2, then two GAP cycles).
  task automatic run2(input logic [2:0] p, input logic fen, input logic fv,
                      input logic e_mis, input int e_err);
    force2 = fen; fval2 = fv;
    valid2 = 1'b1; data2 = p;
    for (int i = 0; i < 10 && !ready2; i++) tick();
    chk("r2_ready_pre", ready2, 1);
    tick();
    valid2 = 1'b0;
    chk("r2_xyz", {x2, y2, z2}, p);
    chk("r2_done_d1", done2, 0);
    tick();
    chk("r2_done", done2, 1);
    chk("r2_mismatch", mis2, e_mis);
    chk("r2_err", err2, e_err);
    chk("r2_xyz_gap", {x2, y2, z2}, 0);
    chk("r2_busy_gap1", busy2, 1);
    tick();
    chk("r2_busy_gap2", busy2, 1);
    chk("r2_done_low", done2, 0);
    tick();
    chk("r2_ready_idle", ready2, 1);
    force2 = 1'b0;
  endtask

  logic [2:0] seq   [3] = '{3'b001, 3'b110, 3'b011};
  logic       exseq [3] = '{1'b0, 1'b1, 1'b1};
  int         acc_c [3];

  initial begin
    int k, dn, e;
    logic acc;
    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_xyz", {x1, y1, z1}, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", ready1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_exp", exp1, 0);
    chk("rst_err_after", err1, 0);

    // Correct evaluator, forced mismatch, then correct again
    run1(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run1(3'b101, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    run1(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Back-to-back with pat_valid held high
    k = 0; dn = 0;
    valid1 = 1'b1; data1 = seq[0];
    for (int c = 0; c < 40 && dn < 3; c++) begin
      acc = ready1 && valid1;
      if (done1) begin
        chk("b2b_exp", exp1, exseq[dn]);
        dn++;
      end
      if (acc) begin
        acc_c[k] = c;
        k++;
      end
      tick();
      if (acc) begin
        if (k < 3) data1 = seq[k];
        else valid1 = 1'b0;
      end
    end
    valid1 = 1'b0;
    chk("b2b_accepts", k, 3);
    chk("b2b_dones", dn, 3);
    if (k == 3) begin
      chk("b2b_gap01", acc_c[1] - acc_c[0], 3);
      chk("b2b_gap12", acc_c[2] - acc_c[1], 3);
    end

    // Saturation on the 2-bit counter, then clear against a mismatch
    for (int i = 0; i < 5; i++) begin
      e = (i + 1 > 3) ? 3 : i + 1;
      run2(3'b111, 1'b1, 1'b0, 1'b1, e);
    end
    chk("sat_err", err2, 3);
    clr2 = 1'b1;
    run2(3'b111, 1'b1, 1'b0, 1'b1, 0);
    clr2 = 1'b0;
    tick();
    chk("clr_err_after", err2, 0);

    // Abort in the first DRIVE cycle
    chk("abort_err_pre", err1, 1);
    valid1 = 1'b1; data1 = 3'b111;
    tick();
    valid1 = 1'b0;
    chk("abort_xyz_drive", {x1, y1, z1}, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_xyz_async", {x1, y1, z1}, 0);
    chk("abort_busy", busy1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    e = 0;
    for (int i = 0; i < 5; i++) begin
      if (done1) e++;
      tick();
    end
    chk("abort_no_done", e, 0);
    chk("abort_ready", ready1, 1);
    chk("abort_err", err1, 0);
    chk("abort_xyz_idle", {x1, y1, z1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
